vga_timing_ctrl: RTL and testbench

Pixel-clock timing and test-pattern source for the HDMI output path. It generates the horizontal and vertical counters and the `hsync`/`vsync`/`rgb_valid` qualifiers, and produces 8-bit RGB for one of four selectable patterns. Its outputs connect directly to the `hsync`, `vsync`, `rgb_valid` and `rgb_red`/`rgb_green`/`rgb_blue` inputs of `hdmi_ctrl`, so it forms the stage immediately upstream of the TMDS encoders.

---
 rtl/vga_pkg.sv | 47 ++++
 rtl/vga_timing_ctrl_if.sv | 27 ++
 rtl/vga_pattern_gen.sv | 40 ++++
 rtl/vga_timing_ctrl.sv | 113 +++++++++++
 tb/tb_vga_timing_ctrl.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/vga_pkg.sv
// Shared timing defaults, pattern encodings and colour-bar palette for the VGA timing block.
// Imported by the interface, the pattern generator and the timing controller.
package vga_pkg;

  localparam int unsigned CNT_W = 10;

  // 640x480@60 defaults
  localparam int unsigned DEF_H_SYNC  = 96;
  localparam int unsigned DEF_H_BACK  = 48;
  localparam int unsigned DEF_H_VALID = 640;
  localparam int unsigned DEF_H_FRONT = 16;
  localparam int unsigned DEF_V_SYNC  = 2;
  localparam int unsigned DEF_V_BACK  = 33;
  localparam int unsigned DEF_V_VALID = 480;
  localparam int unsigned DEF_V_FRONT = 10;

  typedef logic [1:0]  pattern_t;
  typedef logic [23:0] rgb_t;

  localparam pattern_t PAT_COLORBAR = 2'd0;
  localparam pattern_t PAT_GRAY     = 2'd1;
  localparam pattern_t PAT_CHECKER  = 2'd2;
  localparam pattern_t PAT_WHITE    = 2'd3;

  localparam rgb_t COLOR_WHITE   = 24'hFFFFFF;
  localparam rgb_t COLOR_YELLOW  = 24'hFFFF00;
  localparam rgb_t COLOR_CYAN    = 24'h00FFFF;
  localparam rgb_t COLOR_GREEN   = 24'h00FF00;
  localparam rgb_t COLOR_MAGENTA = 24'hFF00FF;
  localparam rgb_t COLOR_RED     = 24'hFF0000;
  localparam rgb_t COLOR_BLUE    = 24'h0000FF;
  localparam rgb_t COLOR_BLACK   = 24'h000000;

  function automatic rgb_t bar_color(input logic [2:0] idx);
    case (idx)
      3'd0:    bar_color = COLOR_WHITE;
      3'd1:    bar_color = COLOR_YELLOW;
      3'd2:    bar_color = COLOR_CYAN;
      3'd3:    bar_color = COLOR_GREEN;
      3'd4:    bar_color = COLOR_MAGENTA;
      3'd5:    bar_color = COLOR_RED;
      3'd6:    bar_color = COLOR_BLUE;
      default: bar_color = COLOR_BLACK;
    endcase
  endfunction

endpackage

// File: rtl/vga_timing_ctrl_if.sv
// Video bus between the timing/pattern source and the HDMI encoder stage.
// master = timing source side, slave = downstream consumer side.
interface vga_timing_ctrl_if;
  import vga_pkg::*;

  pattern_t         pattern_sel;
  logic             hsync;
  logic             vsync;
  logic             rgb_valid;
  logic [7:0]       rgb_red;
  logic [7:0]       rgb_green;
  logic [7:0]       rgb_blue;
  logic [CNT_W-1:0] pix_x;
  logic [CNT_W-1:0] pix_y;
  logic             frame_start;

  modport master (
    input  pattern_sel,
    output hsync, vsync, rgb_valid, rgb_red, rgb_green, rgb_blue, pix_x, pix_y, frame_start
  );

  modport slave (
    output pattern_sel,
    input  hsync, vsync, rgb_valid, rgb_red, rgb_green, rgb_blue, pix_x, pix_y, frame_start
  );

endinterface

// File: rtl/vga_pattern_gen.sv
// Combinational test-pattern map from (pattern, active-area position, active) to 24-bit RGB.
// Colour-bar index comes from boundary compares, so no divider is built.
module vga_pattern_gen
  import vga_pkg::*;
#(
  parameter int unsigned H_VALID = DEF_H_VALID
) (
  input  pattern_t         pattern,
  input  logic [CNT_W-1:0] pix_x,
  input  logic             y_tile,   // pix_y[5], the only row bit the checkerboard needs
  input  logic             active,
  output rgb_t             rgb
);

  localparam int unsigned BarW = H_VALID / 8;

  logic [2:0] bar_idx;

  always_comb begin
    bar_idx = 3'd0;
    for (int unsigned i = 1; i < 8; i++) begin
      if (pix_x >= CNT_W'(i * BarW)) begin
        bar_idx = 3'(i);
      end
    end
  end

  always_comb begin
    rgb = COLOR_BLACK;
    if (active) begin
      case (pattern)
        PAT_COLORBAR: rgb = bar_color(bar_idx);
        PAT_GRAY:     rgb = {3{pix_x[9:2]}};
        PAT_CHECKER:  rgb = (pix_x[5] ^ y_tile) ? COLOR_WHITE : COLOR_BLACK;
        default:      rgb = COLOR_WHITE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_ctrl.sv
// Pixel-clock h/v counters, sync and active-area decode, and a single output register stage.
// All outputs reflect the counter state of the previous cycle, so they are mutually aligned.
module vga_timing_ctrl
  import vga_pkg::*;
#(
  parameter int unsigned H_SYNC  = DEF_H_SYNC,
  parameter int unsigned H_BACK  = DEF_H_BACK,
  parameter int unsigned H_VALID = DEF_H_VALID,
  parameter int unsigned H_FRONT = DEF_H_FRONT,
  parameter int unsigned V_SYNC  = DEF_V_SYNC,
  parameter int unsigned V_BACK  = DEF_V_BACK,
  parameter int unsigned V_VALID = DEF_V_VALID,
  parameter int unsigned V_FRONT = DEF_V_FRONT
) (
  input  logic              vga_clk,
  input  logic              sys_rst_n,
  vga_timing_ctrl_if.master bus
);

  localparam int unsigned H_TOTAL = H_SYNC + H_BACK + H_VALID + H_FRONT;
  localparam int unsigned V_TOTAL = V_SYNC + V_BACK + V_VALID + V_FRONT;

  localparam logic [CNT_W-1:0] H_LAST     = CNT_W'(H_TOTAL - 1);
  localparam logic [CNT_W-1:0] V_LAST     = CNT_W'(V_TOTAL - 1);
  localparam logic [CNT_W-1:0] H_SYNC_END = CNT_W'(H_SYNC);
  localparam logic [CNT_W-1:0] V_SYNC_END = CNT_W'(V_SYNC);
  localparam logic [CNT_W-1:0] H_ACT_BEG  = CNT_W'(H_SYNC + H_BACK);
  localparam logic [CNT_W-1:0] H_ACT_END  = CNT_W'(H_SYNC + H_BACK + H_VALID);
  localparam logic [CNT_W-1:0] V_ACT_BEG  = CNT_W'(V_SYNC + V_BACK);
  localparam logic [CNT_W-1:0] V_ACT_END  = CNT_W'(V_SYNC + V_BACK + V_VALID);

  logic [CNT_W-1:0] h_cnt_q, h_cnt_d;
  logic [CNT_W-1:0] v_cnt_q, v_cnt_d;
  pattern_t         pattern_q, pattern_d;

  logic             frame_top;
  logic             h_act, v_act, active;
  logic             hsync_d, vsync_d;
  logic [CNT_W-1:0] pix_x_d, pix_y_d;
  rgb_t             rgb_d;

  logic             hsync_q, vsync_q, rgb_valid_q, frame_start_q;
  logic [CNT_W-1:0] pix_x_q, pix_y_q;
  rgb_t             rgb_q;

  always_comb begin
    h_cnt_d = h_cnt_q + 1'b1;
    v_cnt_d = v_cnt_q;
    if (h_cnt_q == H_LAST) begin
      h_cnt_d = '0;
      v_cnt_d = (v_cnt_q == V_LAST) ? '0 : v_cnt_q + 1'b1;
    end
  end

  assign frame_top = (h_cnt_q == '0) && (v_cnt_q == '0);
  assign h_act     = (h_cnt_q >= H_ACT_BEG) && (h_cnt_q < H_ACT_END);
  assign v_act     = (v_cnt_q >= V_ACT_BEG) && (v_cnt_q < V_ACT_END);
  assign active    = h_act && v_act;
  assign hsync_d   = (h_cnt_q < H_SYNC_END);
  assign vsync_d   = (v_cnt_q < V_SYNC_END);
  assign pix_x_d   = active ? (h_cnt_q - H_ACT_BEG) : '0;
  assign pix_y_d   = active ? (v_cnt_q - V_ACT_BEG) : '0;

  // Pattern only changes at the top of a frame so a frame is never mixed.
  assign pattern_d = frame_top ? bus.pattern_sel : pattern_q;

  vga_pattern_gen #(
    .H_VALID (H_VALID)
  ) u_pattern_gen (
    .pattern (pattern_q),
    .pix_x   (pix_x_d),
    .y_tile  (pix_y_d[5]),
    .active  (active),
    .rgb     (rgb_d)
  );

  always_ff @(posedge vga_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      h_cnt_q       <= '0;
      v_cnt_q       <= '0;
      pattern_q     <= PAT_COLORBAR;
      hsync_q       <= 1'b0;
      vsync_q       <= 1'b0;
      rgb_valid_q   <= 1'b0;
      frame_start_q <= 1'b0;
      pix_x_q       <= '0;
      pix_y_q       <= '0;
      rgb_q         <= COLOR_BLACK;
    end else begin
      h_cnt_q       <= h_cnt_d;
      v_cnt_q       <= v_cnt_d;
      pattern_q     <= pattern_d;
      hsync_q       <= hsync_d;
      vsync_q       <= vsync_d;
      rgb_valid_q   <= active;
      frame_start_q <= frame_top;
      pix_x_q       <= pix_x_d;
      pix_y_q       <= pix_y_d;
      rgb_q         <= rgb_d;
    end
  end

  assign bus.hsync       = hsync_q;
  assign bus.vsync       = vsync_q;
  assign bus.rgb_valid   = rgb_valid_q;
  assign bus.frame_start = frame_start_q;
  assign bus.pix_x       = pix_x_q;
  assign bus.pix_y       = pix_y_q;
  assign bus.rgb_red     = rgb_q[23:16];
  assign bus.rgb_green   = rgb_q[15:8];
  assign bus.rgb_blue    = rgb_q[7:0];

endmodule

// File: tb/tb_vga_timing_ctrl.sv
// Directed bench for vga_timing_ctrl: full 800-pixel lines with a shortened 38-line frame
// (V 2/1/34/1) so whole-frame behaviour fits in a short run.
module tb_vga_timing_ctrl;
  import vga_pkg::*;

  localparam int HT = 800;
  localparam int VT = 38;

  logic vga_clk = 1'b0;
  logic sys_rst_n;

  vga_timing_ctrl_if vga_bus ();

  vga_timing_ctrl #(
    .H_SYNC  (96),
    .H_BACK  (48),
    .H_VALID (640),
    .H_FRONT (16),
    .V_SYNC  (2),
    .V_BACK  (1),
    .V_VALID (34),
    .V_FRONT (1)
  ) dut (
    .vga_clk   (vga_clk),
    .sys_rst_n (sys_rst_n),
    .bus       (vga_bus.master)
  );

  always #5 vga_clk = ~vga_clk;

  int total = 0;
  int bad   = 0;
  int n;
  int vs_n, fs_last, fs_period;
  int hs_n, rv_n, first_h, last_px, py, blank_bad;
  int white_n;
  logic [23:0] line_rgb [1024];
  logic [23:0] rgb_now;

  assign rgb_now = {vga_bus.rgb_red, vga_bus.rgb_green, vga_bus.rgb_blue};

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  task automatic check_outputs_zero(input string pre);
    check_eq({pre, "_hsync"}, 32'(vga_bus.hsync), 0);
    check_eq({pre, "_vsync"}, 32'(vga_bus.vsync), 0);
    check_eq({pre, "_rgb_valid"}, 32'(vga_bus.rgb_valid), 0);
    check_eq({pre, "_frame_start"}, 32'(vga_bus.frame_start), 0);
    check_eq({pre, "_rgb"}, 32'(rgb_now), 0);
    check_eq({pre, "_pix_x"}, 32'(vga_bus.pix_x), 0);
    check_eq({pre, "_pix_y"}, 32'(vga_bus.pix_y), 0);
  endtask

  // n is the counter state the outputs currently show
  task automatic tick();
    @(posedge vga_clk);
    #1;
    n++;
    vs_n += int'(vga_bus.vsync);
    if (vga_bus.frame_start) begin
      if (fs_last >= 0) fs_period = n - fs_last;
      fs_last = n;
    end
  endtask

  task automatic goto_pos(input int v, input int h);
    int budget;
    budget = 40000;
    while (((n / HT) % VT) != v || (n % HT) != h) begin
      if (budget == 0) begin
        check_eq("goto_budget", 0, 1);
        return;
      end
      budget--;
      tick();
    end
  endtask

  task automatic scan_line(input int v);
    goto_pos(v, 0);
    hs_n = 0; rv_n = 0; first_h = -1; last_px = -1; py = -1; blank_bad = 0;
    foreach (line_rgb[i]) line_rgb[i] = 'x;
    for (int i = 0; i < HT; i++) begin
      hs_n += int'(vga_bus.hsync);
      if (vga_bus.rgb_valid) begin
        rv_n++;
        if (first_h < 0) first_h = i;
        line_rgb[vga_bus.pix_x] = rgb_now;
        last_px = int'(vga_bus.pix_x);
        py      = int'(vga_bus.pix_y);
      end else if (rgb_now != 0 || vga_bus.pix_x != 0 || vga_bus.pix_y != 0) begin
        blank_bad++;
      end
      tick();
    end
  endtask

  task automatic release_reset();
    @(negedge vga_clk);
    sys_rst_n = 1'b1;
    n = -1;
    vs_n = 0; fs_last = -1; fs_period = 0;
    tick();
  endtask

  initial begin
    sys_rst_n = 1'b0;
    vga_bus.pattern_sel = PAT_WHITE;
    n = -1; vs_n = 0; fs_last = -1; fs_period = 0;

    repeat (10) @(posedge vga_clk);
    #1;
    check_outputs_zero("rst");

    // Frame 0: solid white
    release_reset();
    check_eq("first_frame_start", 32'(vga_bus.frame_start), 1);
    check_eq("first_hsync", 32'(vga_bus.hsync), 1);
    check_eq("first_vsync", 32'(vga_bus.vsync), 1);
    check_eq("first_rgb_valid", 32'(vga_bus.rgb_valid), 0);

    scan_line(0);
    check_eq("l0_hsync_cnt", hs_n, 96);
    check_eq("l0_valid_cnt", rv_n, 0);

    scan_line(3);
    check_eq("l3_hsync_cnt", hs_n, 96);
    check_eq("l3_valid_cnt", rv_n, 640);
    check_eq("l3_valid_rise", first_h, 144);
    check_eq("l3_last_px", last_px, 639);
    check_eq("l3_pix_y", py, 0);
    check_eq("l3_blank", blank_bad, 0);
    check_eq("white_px0", 32'(line_rgb[0]), 32'hFFFFFF);
    check_eq("white_px600", 32'(line_rgb[600]), 32'hFFFFFF);

    // Mid-frame switch to colorbar must not show until the next frame
    goto_pos(5, 0);
    vga_bus.pattern_sel = PAT_COLORBAR;
    scan_line(10);
    check_eq("hold_pix_y", py, 7);
    check_eq("hold_white_px100", 32'(line_rgb[100]), 32'hFFFFFF);
    check_eq("hold_white_px600", 32'(line_rgb[600]), 32'hFFFFFF);

    goto_pos(37, 799);
    check_eq("vsync_cnt", vs_n, 1600);
    tick();
    check_eq("frame_start_again", 32'(vga_bus.frame_start), 1);
    check_eq("frame_period", fs_period, 30400);

    // Frame 1: colorbar
    scan_line(3);
    white_n = 0;
    for (int i = 0; i < 80; i++) if (line_rgb[i] === 24'hFFFFFF) white_n++;
    check_eq("bar0_width", white_n, 80);
    check_eq("bar_px79", 32'(line_rgb[79]), 32'hFFFFFF);
    check_eq("bar_px80", 32'(line_rgb[80]), 32'hFFFF00);
    check_eq("bar_px160", 32'(line_rgb[160]), 32'h00FFFF);
    check_eq("bar_px240", 32'(line_rgb[240]), 32'h00FF00);
    check_eq("bar_px320", 32'(line_rgb[320]), 32'hFF00FF);
    check_eq("bar_px400", 32'(line_rgb[400]), 32'hFF0000);
    check_eq("bar_px480", 32'(line_rgb[480]), 32'h0000FF);
    check_eq("bar_px560", 32'(line_rgb[560]), 32'h000000);
    check_eq("bar_px639", 32'(line_rgb[639]), 32'h000000);
    check_eq("bar_blank", blank_bad, 0);

    // Async reset mid-line while a yellow pixel is showing
    goto_pos(4, 300);
    check_eq("pre_rst_valid", 32'(vga_bus.rgb_valid), 1);
    #2;
    sys_rst_n = 1'b0;
    #1;
    check_outputs_zero("midrst");
    vga_bus.pattern_sel = PAT_GRAY;
    repeat (2) @(posedge vga_clk);
    release_reset();
    check_eq("restart_frame_start", 32'(vga_bus.frame_start), 1);
    check_eq("restart_hsync", 32'(vga_bus.hsync), 1);

    // Gray ramp
    scan_line(3);
    check_eq("restart_valid_rise", first_h, 144);
    check_eq("gray_px639", 32'(line_rgb[639]), 32'h9F9F9F);
    check_eq("gray_px256", 32'(line_rgb[256]), 32'h404040);

    // Checkerboard via another reset
    @(negedge vga_clk);
    sys_rst_n = 1'b0;
    vga_bus.pattern_sel = PAT_CHECKER;
    repeat (2) @(posedge vga_clk);
    release_reset();
    scan_line(3);
    check_eq("chk_32_0", 32'(line_rgb[32]), 32'hFFFFFF);
    check_eq("chk_0_0", 32'(line_rgb[0]), 32'h000000);
    check_eq("chk_64_0", 32'(line_rgb[64]), 32'h000000);
    scan_line(35);
    check_eq("chk_row32_pix_y", py, 32);
    check_eq("chk_32_32", 32'(line_rgb[32]), 32'h000000);
    check_eq("chk_0_32", 32'(line_rgb[0]), 32'hFFFFFF);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
